// File: rtl/wave_capture_if.sv
// Bundles the sample-source input and the sample-memory write bus of the
// waveform capture scheduler. The controller uses the master view; the environment uses the slave view.
interface wave_capture_if #(
    parameter int DW = 10,
    parameter int AW = 10
);
    logic          sample_valid;
    logic [DW-1:0] wave_sample;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_bank;
    logic          rd_bank;
    logic          frame_done;

    modport master (
        input  sample_valid, wave_sample,
        output wr_en, wr_addr, wr_data, wr_bank, rd_bank, frame_done
    );

    modport slave (
        output sample_valid, wave_sample,
        input  wr_en, wr_addr, wr_data, wr_bank, rd_bank, frame_done
    );
endinterface

// File: rtl/wave_capture_ctrl.sv
// Ping-pong capture scheduler: arms on a rising-edge trigger (or auto timeout), decimates,
// writes one frame of COLS samples into the write bank, then swaps banks for the display.
module wave_capture_ctrl #(
    parameter int COLS       = 640,
    parameter int DW         = 10,
    parameter int TRIG_LEVEL = 512,
    parameter int TIMEOUT    = 2000
) (
    input  logic                  clk_sample,
    input  logic                  rst_n,
    wave_capture_if.master        bus,
    input  logic                  freeze,
    input  logic                  trig_mode,
    input  logic [3:0]            decim,
    output logic [1:0]            state,
    output logic                  triggered
);
    localparam int AW = 10;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [DW-1:0] TRIG      = DW'(TRIG_LEVEL);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(COLS - 1);

    typedef enum logic [1:0] {
        ST_ARM     = 2'b00,
        ST_CAPTURE = 2'b01,
        ST_FROZEN  = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    dec_cnt_q, dec_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [DW-1:0] prev_q, prev_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic          frame_done_q, frame_done_d;
    logic          triggered_q, triggered_d;

    logic accepted;
    logic rising;
    logic forced;

    always_comb begin
        accepted = bus.sample_valid && (dec_cnt_q == 4'd0);
        rising   = (prev_q < TRIG) && (bus.wave_sample >= TRIG);
        forced   = !trig_mode && (to_cnt_q == TO_LAST);

        state_d      = state_q;
        dec_cnt_d    = dec_cnt_q;
        to_cnt_d     = to_cnt_q;
        prev_d       = prev_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        frame_done_d = 1'b0;

        // Decimation and trigger history run in every state, including FROZEN.
        if (bus.sample_valid) begin
            dec_cnt_d = accepted ? decim : dec_cnt_q - 4'd1;
        end
        if (accepted) begin
            prev_d = bus.wave_sample;
        end

        case (state_q)
            ST_ARM: begin
                if (freeze) begin
                    state_d  = ST_FROZEN;
                    to_cnt_d = '0;
                end else if (accepted) begin
                    if (rising || forced) begin
                        state_d   = ST_CAPTURE;
                        wr_en_d   = 1'b1;
                        wr_addr_d = '0;
                        wr_data_d = bus.wave_sample;
                        to_cnt_d  = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
                if (trig_mode) begin
                    to_cnt_d = '0;
                end
            end
            ST_CAPTURE: begin
                // The cycle after the last column write always completes the swap,
                // even if freeze arrives together with it.
                if (wr_addr_q == LAST_ADDR) begin
                    frame_done_d = 1'b1;
                    rd_bank_d    = wr_bank_q;
                    wr_bank_d    = ~wr_bank_q;
                    wr_addr_d    = '0;
                    state_d      = freeze ? ST_FROZEN : ST_ARM;
                end else if (freeze) begin
                    state_d = ST_FROZEN;
                end else if (accepted) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                    wr_data_d = bus.wave_sample;
                end
            end
            ST_FROZEN: begin
                if (!freeze) begin
                    state_d   = ST_ARM;
                    wr_addr_d = '0;
                    to_cnt_d  = '0;
                end
            end
            default: begin
                state_d = ST_ARM;
            end
        endcase

        triggered_d = (state_d == ST_CAPTURE);
    end

    always_ff @(posedge clk_sample) begin
        if (!rst_n) begin
            state_q      <= ST_ARM;
            dec_cnt_q    <= 4'd0;
            to_cnt_q     <= '0;
            prev_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b1;
            frame_done_q <= 1'b0;
            triggered_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dec_cnt_q    <= dec_cnt_d;
            to_cnt_q     <= to_cnt_d;
            prev_q       <= prev_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            frame_done_q <= frame_done_d;
            triggered_q  <= triggered_d;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.wr_bank    = wr_bank_q;
    assign bus.rd_bank    = rd_bank_q;
    assign bus.frame_done = frame_done_q;
    assign state          = state_q;
    assign triggered      = triggered_q;

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Directed bench for wave_capture_ctrl: expected writes are queued as samples are driven
// and matched against every wr_en pulse; control outputs are checked at key points.
module tb_wave_capture_ctrl;
    logic       clk_sample = 1'b0;
    logic       rst_n;
    logic       freeze;
    logic       trig_mode;
    logic [3:0] decim;
    logic [1:0] state;
    logic       triggered;

    int vectors     = 0;
    int miscompares = 0;
    int n_writes    = 0;

    typedef struct {
        logic [9:0] addr;
        logic [9:0] data;
        logic       bank;
    } wr_t;
    wr_t sb[$];

    wave_capture_if #(.DW(10), .AW(10)) bus ();

    wave_capture_ctrl #(
        .COLS(640), .DW(10), .TRIG_LEVEL(512), .TIMEOUT(2000)
    ) dut (
        .clk_sample (clk_sample),
        .rst_n      (rst_n),
        .bus        (bus),
        .freeze     (freeze),
        .trig_mode  (trig_mode),
        .decim      (decim),
        .state      (state),
        .triggered  (triggered)
    );

    always #5 clk_sample = ~clk_sample;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic exp_wr(input int addr, input int data, input logic bank);
        wr_t e;
        e.addr = 10'(addr);
        e.data = 10'(data);
        e.bank = bank;
        sb.push_back(e);
    endtask

    // Drive one sample cycle; returns 1 time unit after the edge that registered it.
    task automatic apply(input logic v, input int s);
        bus.sample_valid = v;
        bus.wave_sample  = 10'(s);
        @(posedge clk_sample);
        #1;
    endtask

    // Every write strobe must match the oldest queued expectation.
    always @(negedge clk_sample) begin
        if (bus.wr_en === 1'b1) begin
            wr_t e;
            n_writes++;
            $display("write addr=%0d data=%0d bank=%0d", bus.wr_addr, bus.wr_data, bus.wr_bank);
            chk("write_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                chk("wr_data", 32'(bus.wr_data), 32'(e.data));
                chk("wr_bank", 32'(bus.wr_bank), 32'(e.bank));
            end
        end
    end

    initial begin
        int base;
        rst_n            = 1'b0;
        freeze           = 1'b0;
        trig_mode        = 1'b1;
        decim            = 4'd0;
        bus.sample_valid = 1'b0;
        bus.wave_sample  = '0;
        apply(0, 0);
        apply(0, 0);
        chk("rst_state", 32'(state), 0);
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 0);
        chk("rst_wr_data", 32'(bus.wr_data), 0);
        chk("rst_wr_bank", 32'(bus.wr_bank), 0);
        chk("rst_rd_bank", 32'(bus.rd_bank), 1);
        chk("rst_frame_done", 32'(bus.frame_done), 0);
        chk("rst_triggered", 32'(triggered), 0);
        rst_n = 1'b1;
        apply(0, 0);

        // Ramp step 8, normal mode: trigger on sample 512 (k=64), frame into bank 0.
        $display("phase ramp trigger");
        for (int k = 0; k < 704; k++) begin
            if (k >= 64) exp_wr(k - 64, (k * 8) & 1023, 1'b0);
            apply(1, (k * 8) & 1023);
            if (k == 63) chk("ramp_pre_trig_state", 32'(state), 0);
            if (k == 64) begin
                chk("ramp_trig_state", 32'(state), 1);
                chk("ramp_triggered", 32'(triggered), 1);
                chk("ramp_rd_ne_wr", 32'(bus.rd_bank != bus.wr_bank), 1);
            end
        end
        apply(0, 0);
        chk("ramp_frame_done", 32'(bus.frame_done), 1);
        chk("ramp_rd_bank", 32'(bus.rd_bank), 0);
        chk("ramp_wr_bank", 32'(bus.wr_bank), 1);
        chk("ramp_state_arm", 32'(state), 0);
        chk("ramp_wr_addr0", 32'(bus.wr_addr), 0);
        apply(0, 0);
        chk("ramp_frame_done_pulse", 32'(bus.frame_done), 0);
        chk("ramp_sb_empty", 32'(sb.size()), 0);
        chk("ramp_write_count", 32'(n_writes), 640);

        // Auto mode, constant 100: forced trigger on accepted sample 2000.
        $display("phase auto timeout");
        trig_mode = 1'b0;
        for (int n = 1; n <= 2000; n++) begin
            if (n == 2000) exp_wr(0, 100, 1'b1);
            apply(1, 100);
            if (n == 1999) chk("timeout_still_arm", 32'(state), 0);
        end
        chk("timeout_state_capture", 32'(state), 1);
        for (int i = 1; i <= 100; i++) begin
            exp_wr(i, 100, 1'b1);
            apply(1, 100);
        end
        chk("midcap_wr_addr", 32'(bus.wr_addr), 100);

        // Reset in the middle of a capture discards the frame.
        $display("phase reset mid-capture");
        rst_n = 1'b0;
        apply(1, 100);
        chk("mrst_state", 32'(state), 0);
        chk("mrst_wr_en", 32'(bus.wr_en), 0);
        chk("mrst_wr_addr", 32'(bus.wr_addr), 0);
        chk("mrst_wr_data", 32'(bus.wr_data), 0);
        chk("mrst_wr_bank", 32'(bus.wr_bank), 0);
        chk("mrst_rd_bank", 32'(bus.rd_bank), 1);
        chk("mrst_frame_done", 32'(bus.frame_done), 0);
        chk("mrst_triggered", 32'(triggered), 0);
        rst_n = 1'b1;
        chk("mrst_sb_empty", 32'(sb.size()), 0);

        // Normal mode, constant 100: no trigger ever.
        $display("phase normal no trigger");
        trig_mode = 1'b1;
        for (int n = 0; n < 2500; n++) apply(1, 100);
        chk("normal_state_arm", 32'(state), 0);
        chk("normal_wr_en", 32'(bus.wr_en), 0);

        // decim=3: one write per four valid samples, 2560 samples per frame.
        $display("phase decimation");
        decim = 4'd3;
        base  = n_writes;
        for (int j = 0; j < 2560; j++) begin
            int v;
            v = (j == 0) ? 600 : ((j * 3) & 1023);
            if (j % 4 == 0) exp_wr(j / 4, v, 1'b0);
            apply(1, v);
            if (j == 2557) begin
                chk("decim_frame_done", 32'(bus.frame_done), 1);
                chk("decim_wr_bank", 32'(bus.wr_bank), 1);
                chk("decim_rd_bank", 32'(bus.rd_bank), 0);
            end
        end
        chk("decim_write_count", 32'(n_writes - base), 640);
        chk("decim_sb_empty", 32'(sb.size()), 0);

        // Freeze at addr 300 aborts the frame; release restarts at addr 0, same bank.
        $display("phase freeze abort");
        decim = 4'd0;
        exp_wr(0, 700, 1'b1);
        apply(1, 700);
        for (int i = 1; i <= 300; i++) begin
            exp_wr(i, (i * 5) & 1023, 1'b1);
            apply(1, (i * 5) & 1023);
        end
        chk("frz_at_300", 32'(bus.wr_addr), 300);
        freeze = 1'b1;
        apply(1, 900);
        chk("frz_state", 32'(state), 2);
        chk("frz_frame_done", 32'(bus.frame_done), 0);
        chk("frz_rd_bank", 32'(bus.rd_bank), 0);
        chk("frz_wr_bank", 32'(bus.wr_bank), 1);
        chk("frz_triggered", 32'(triggered), 0);
        for (int i = 0; i < 20; i++) apply(1, (i % 2 == 0) ? 900 : 200);
        chk("frz_hold_state", 32'(state), 2);
        chk("frz_hold_rd_bank", 32'(bus.rd_bank), 0);
        freeze = 1'b0;
        apply(0, 0);
        chk("unfrz_state", 32'(state), 0);
        chk("unfrz_wr_addr", 32'(bus.wr_addr), 0);
        chk("frz_sb_empty", 32'(sb.size()), 0);

        // New frame in bank 1; freeze lands with the addr-639 write: swap still completes.
        $display("phase freeze at final write");
        exp_wr(0, 800, 1'b1);
        apply(1, 800);
        chk("refrm_triggered", 32'(triggered), 1);
        for (int i = 1; i < 640; i++) begin
            exp_wr(i, (i * 7) & 1023, 1'b1);
            apply(1, (i * 7) & 1023);
        end
        chk("final_wr_addr", 32'(bus.wr_addr), 639);
        freeze = 1'b1;
        apply(0, 0);
        chk("final_frame_done", 32'(bus.frame_done), 1);
        chk("final_wr_bank", 32'(bus.wr_bank), 0);
        chk("final_rd_bank", 32'(bus.rd_bank), 1);
        chk("final_state", 32'(state), 2);
        chk("final_wr_en", 32'(bus.wr_en), 0);
        freeze = 1'b0;
        apply(0, 0);
        chk("final_unfrz_state", 32'(state), 0);
        chk("final_sb_empty", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
